// File: rtl/mode_state_controller_pkg.sv
// Shared definitions for the exhaust hood mode controller: mode encodings,
// default timed-mode durations and a small mode classification helper.
package mode_state_controller_pkg;

  localparam int MODE_WIDTH            = 3;
  localparam int THIRD_SECONDS_DEFAULT = 60;
  localparam int CLEAN_SECONDS_DEFAULT = 180;

  typedef enum logic [MODE_WIDTH-1:0] {
    OFF_MODE    = 3'd0,
    STAND_MODE  = 3'd1,
    FIRST_MODE  = 3'd2,
    SECOND_MODE = 3'd3,
    THIRD_MODE  = 3'd4,
    CLEAN_MODE  = 3'd5
  } mode_e;

  // Timed modes own the seconds countdown; every other mode shows 0.
  function automatic logic is_timed(input mode_e m);
    return (m == THIRD_MODE) || (m == CLEAN_MODE);
  endfunction

endpackage

// File: rtl/mode_state_controller_ticker.sv
// One-second prescaler: emits a single-cycle tick every TICK_CYCLES clocks,
// restarting a full period whenever clear is asserted.
module one_second_ticker #(
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mode_state_controller.sv
// Central hood mode register: arbitrates level requests from the per-mode
// stages and runs the hurricane and self-clean countdowns.
module mode_state_controller
  import mode_state_controller_pkg::*;
#(
  parameter int TICK_CYCLES   = 100_000_000,
  parameter int THIRD_SECONDS = THIRD_SECONDS_DEFAULT,
  parameter int CLEAN_SECONDS = CLEAN_SECONDS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  power_on_req,
  input  logic                  power_off_req,
  input  logic                  stand_req,
  input  logic                  first_req,
  input  logic                  second_req,
  input  logic                  third_req,
  input  logic                  clean_req,
  output logic [MODE_WIDTH-1:0] current_mode,
  output logic [7:0]            countdown_sec,
  output logic                  third_used,
  output logic                  mode_changed,
  output logic                  clean_done
);

  mode_e      mode_q, mode_d;
  logic [7:0] count_q, count_d;
  logic       third_used_q, third_used_d;
  logic       mode_changed_q, mode_changed_d;
  logic       clean_done_q, clean_done_d;
  logic       tick;

  // Restart the prescaler on the same edge the mode changes so every timed
  // mode gets a full first second.
  one_second_ticker #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_ticker (
    .clk  (clk),
    .rstn (rstn),
    .clear(mode_changed_d),
    .tick (tick)
  );

  always_comb begin
    mode_d       = mode_q;
    count_d      = count_q;
    third_used_d = third_used_q;
    clean_done_d = 1'b0;

    case (mode_q)
      OFF_MODE: begin
        if (power_on_req) mode_d = STAND_MODE;
      end
      STAND_MODE: begin
        if (power_off_req) begin
          mode_d = OFF_MODE;
        end else if (clean_req) begin
          mode_d  = CLEAN_MODE;
          count_d = 8'(CLEAN_SECONDS);
        end else if (third_req && !third_used_q) begin
          mode_d       = THIRD_MODE;
          count_d      = 8'(THIRD_SECONDS);
          third_used_d = 1'b1;
        end else if (second_req) begin
          mode_d = SECOND_MODE;
        end else if (first_req) begin
          mode_d = FIRST_MODE;
        end
      end
      FIRST_MODE: begin
        if (power_off_req)   mode_d = OFF_MODE;
        else if (stand_req)  mode_d = STAND_MODE;
        else if (second_req) mode_d = SECOND_MODE;
      end
      SECOND_MODE: begin
        if (power_off_req)  mode_d = OFF_MODE;
        else if (stand_req) mode_d = STAND_MODE;
        else if (first_req) mode_d = FIRST_MODE;
      end
      THIRD_MODE, CLEAN_MODE: begin
        // Power-off outranks expiry; everything else is ignored here.
        if (power_off_req) begin
          mode_d = OFF_MODE;
        end else if (tick) begin
          if (count_q <= 8'd1) begin
            mode_d       = STAND_MODE;
            clean_done_d = (mode_q == CLEAN_MODE);
          end else begin
            count_d = count_q - 8'd1;
          end
        end
      end
      default: begin
        mode_d = STAND_MODE;
      end
    endcase

    if (mode_d == OFF_MODE && mode_q != OFF_MODE) begin
      third_used_d = 1'b0;
    end
    if (!is_timed(mode_d)) begin
      count_d = 8'd0;
    end
    mode_changed_d = (mode_d != mode_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q         <= OFF_MODE;
      count_q        <= 8'd0;
      third_used_q   <= 1'b0;
      mode_changed_q <= 1'b0;
      clean_done_q   <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      count_q        <= count_d;
      third_used_q   <= third_used_d;
      mode_changed_q <= mode_changed_d;
      clean_done_q   <= clean_done_d;
    end
  end

  assign current_mode  = mode_q;
  assign countdown_sec = count_q;
  assign third_used    = third_used_q;
  assign mode_changed  = mode_changed_q;
  assign clean_done    = clean_done_q;

endmodule
